lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the core's execute stage and the word-only data memory.
- Accepts byte, halfword and word requests in RV32I funct3 encoding.
- Issues aligned word accesses to the memory port. Performs read-modify-write for SB/SH, since the memory writes only full aligned words.
- Extracts and sign/zero-extends load data, and flags misaligned or illegal accesses as faults.

Parameters:
ADDR_W, 32, byte-address width on both core and memory sides.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  core request valid
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data (low bits used for SB/SH)
resp_valid  output  1  single-cycle completion pulse
resp_rdata  output  32  extended load data (0 for stores and faults)
resp_fault  output  1  misaligned/illegal access, qualified by resp_valid
mem_we  output  1  memory write enable (memory samples on clk rising edge)
mem_addr  output  ADDR_W  word-aligned memory address, bits [1:0] always 0
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data, combinational from mem_addr

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active-low on rst_n.
- Reset values:
  - State = IDLE; req_ready = 1 once rst_n deasserts.
  - resp_valid, resp_fault, mem_we = 0.
  - resp_rdata, mem_addr, mem_wd = 0.
  - Requests are ignored while rst_n = 0.
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE:
  - On req_valid && req_ready, latch we, funct3, addr, wdata.
  - Legal and aligned request -> ACCESS.
  - Otherwise -> RESP with fault set.
- Legality:
  - Loads: funct3 in {0,1,2,4,5}.
  - Stores: funct3 in {0,1,2}.
  - Anything else is a fault.
- Alignment:
  - H/HU: addr[0] = 0.
  - W: addr[1:0] = 0.
  - Byte accesses: any address.
  - Misaligned is a fault.
- ACCESS (one cycle): mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Load: select byte lane addr[1:0] (halfword lane addr[1]). Extend: B/H sign-extend, BU/HU zero-extend, W pass-through. Register the result into resp_rdata -> RESP.
  - SW: mem_we = 1, mem_wd = wdata -> RESP.
  - SB/SH: register merge word = mem_rd with the target lane replaced by wdata[7:0] or wdata[15:0] -> MERGE_WR.
- MERGE_WR (one cycle): mem_we = 1, mem_addr unchanged, mem_wd = merge word -> RESP.
- RESP (one cycle):
  - resp_valid = 1; resp_fault valid; then -> IDLE.
  - No response backpressure; the core must accept the pulse.
- Latency, counting accept edge as cycle 0 (resp_valid high during the cycle shown):
  - Load and SW: cycle 2.
  - SB/SH: cycle 3.
  - Fault: cycle 1.
- Throughput: req_ready is low outside IDLE. Back-to-back requests are spaced by latency + 1 cycles.
- Combinational outputs: mem_we and req_ready decode from the state register.
  - mem_we = 0 and mem_wd = 0 in every state except the write cycle.
  - mem_addr = 0 in IDLE.
- Faulting requests never assert mem_we.
- resp_rdata is held until the next RESP or reset. It is 0 for stores and faults.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_we drops asynchronously. No partial write occurs after rst_n falls. No resp_valid is issued for the aborted request.
- Address bits above the memory's decoded range pass through unchanged; wrap-around is the memory's concern.

Test Plan:
- Load word: memory word 0x10 = 0x8081_F2F3; load LW 0x10 -> resp_valid at cycle 2, resp_rdata = 0x8081_F2F3, resp_fault = 0, mem_we never asserted.
- Signed/unsigned byte and half extension (same word):
  - LB 0x11 -> 0xFFFF_FFF2
  - LBU 0x11 -> 0x0000_00F2
  - LH 0x12 -> 0xFFFF_8081
  - LHU 0x12 -> 0x0000_8081
- SB read-modify-write: word 0x20 = 0x1122_3344; SB addr 0x22, wdata 0xAB -> one mem_we pulse in cycle 2 with mem_wd = 0x11AB_3344; resp_valid at cycle 3; subsequent LW 0x20 returns 0x11AB_3344.
- SH/SW write data:
  - SH addr 0x26, wdata 0xBEEF, word 0x24 = 0 -> mem_wd = 0xBEEF_0000.
  - SW addr 0x28, 0xDEAD_BEEF -> mem_we in cycle 1, resp_valid in cycle 2.
- Faults:
  - LW 0x31, SH 0x33, and a load with funct3 = 3 each -> resp_valid at cycle 1 with resp_fault = 1, resp_rdata = 0, no mem_we.
  - req_ready returns high at cycle 2.
- Reset mid-operation: assert rst_n low during MERGE_WR of an SB -> mem_we falls immediately and the memory word is unchanged. After release, req_ready = 1, no resp_valid, and the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the execute stage and a word-only data memory.
// Byte, halfword and word requests arrive in RV32I funct3 encoding. Only
// aligned word accesses are issued to memory. SB/SH use read-modify-write.
// Load data is sign- or zero-extended. Illegal or misaligned requests
// complete as faults and never write memory.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_funct3    store flag and width code (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   req_addr, req_wdata   byte address and store data
//   resp_valid            single-cycle completion pulse
//   resp_rdata            extended load data (0 for stores and faults)
//   resp_fault            illegal/misaligned flag, qualified by resp_valid
//   mem_we, mem_addr      word write enable and word-aligned address
//   mem_wd, mem_rd        write data and combinational read data
module lsu_mem_ctrl #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

   state_t              state_q, state_d;
   logic                we_q;
   logic [2:0]          f3_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         merge_q;
   logic [31:0]         rdata_q;
   logic                fault_q;

   logic                req_ok;
   logic                legal;
   logic                aligned;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [31:0]         load_ext;
   logic [31:0]         merge_word;
   logic [ADDR_W-1:0]   word_addr;

   assign resp_rdata = rdata_q;

   // Next state, memory port decode, request checks and lane datapath
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_fault = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wd     = '0;
      word_addr  = {addr_q[ADDR_W-1:2], 2'b00};

      legal = req_we ? (req_funct3 inside {3'd0, 3'd1, 3'd2})
                     : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      case (req_funct3[1:0])
         2'd1:    aligned = ~req_addr[0];
         2'd2:    aligned = (req_addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      req_ok = legal & aligned;

      case (addr_q[1:0])
         2'd0:    byte_sel = mem_rd[7:0];
         2'd1:    byte_sel = mem_rd[15:8];
         2'd2:    byte_sel = mem_rd[23:16];
         default: byte_sel = mem_rd[31:24];
      endcase
      half_sel = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

      case (f3_q)
         3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
         3'd4:    load_ext = {24'd0, byte_sel};
         3'd5:    load_ext = {16'd0, half_sel};
         default: load_ext = mem_rd;
      endcase

      // Replace the target lane of the fetched word with the store data
      merge_word = mem_rd;
      if (f3_q[1:0] == 2'd0) begin
         case (addr_q[1:0])
            2'd0:    merge_word[7:0]   = wdata_q[7:0];
            2'd1:    merge_word[15:8]  = wdata_q[7:0];
            2'd2:    merge_word[23:16] = wdata_q[7:0];
            default: merge_word[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merge_word[31:16] = wdata_q[15:0];
      end else begin
         merge_word[15:0]  = wdata_q[15:0];
      end

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = req_ok ? ACCESS : RESP;
         end
         ACCESS: begin
            mem_addr = word_addr;
            if (we_q && f3_q[1:0] == 2'd2) begin
               mem_we  = 1'b1;
               mem_wd  = wdata_q;
               state_d = RESP;
            end else if (we_q) begin
               state_d = MERGE_WR;
            end else begin
               state_d = RESP;
            end
         end
         MERGE_WR: begin
            mem_addr = word_addr;
            mem_we   = 1'b1;
            mem_wd   = merge_q;
            state_d  = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_fault = fault_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register and request/result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  fault_q <= ~req_ok;
                  if (!req_ok) rdata_q <= '0;
               end
            end
            ACCESS: begin
               if (!we_q)                      rdata_q <= load_ext;
               else if (f3_q[1:0] == 2'd2)     rdata_q <= '0;
               else                            merge_q <= merge_word;
            end
            MERGE_WR: rdata_q <= '0;
            default: ;
         endcase
      end
   end

endmodule
